taxi_eth_phy_10g_rx_frame_sync: RTL and testbench



---
 rtl/taxi_eth_phy_10g_rx_frame_sync.sv | 219 +++++++++++++++++++++
 tb/tb_taxi_eth_phy_10g_rx_frame_sync.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/taxi_eth_phy_10g_rx_frame_sync.sv
`default_nettype none
// ============================================================================
// Module      : taxi_eth_phy_10g_rx_frame_sync
// Description : 10GBASE-R receive block-lock acquisition and BER monitor.
//               Issues bitslip pulses until 64 consecutive sync headers are
//               valid, then watches the header error rate for loss of lock
//               and high BER, and keeps a saturating bad-header count.
// Revision    : 1.0 - initial release
// ============================================================================
module taxi_eth_phy_10g_rx_frame_sync #(
    parameter int HDR_W        = 2,      // only 2 is supported
    parameter int BITSLIP_WAIT = 8,
    parameter int COUNT_125US  = 19531
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [HDR_W-1:0] serdes_rx_hdr,
    input  logic             serdes_rx_hdr_valid,
    output logic             serdes_rx_bitslip,
    output logic             rx_block_lock,
    output logic             rx_high_ber,
    output logic             rx_status,
    output logic [15:0]      rx_bad_hdr_cnt
);

    // Counter widths; clamp to one bit so degenerate parameters still elaborate
    localparam int SLIP_W  = (BITSLIP_WAIT > 1) ? $clog2(BITSLIP_WAIT) : 1;
    localparam int TIMER_W = (COUNT_125US  > 1) ? $clog2(COUNT_125US)  : 1;

    localparam logic [SLIP_W-1:0]  SLIP_LAST  = SLIP_W'(BITSLIP_WAIT - 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(COUNT_125US - 1);

    localparam logic [6:0] SH_LAST   = 7'd63;   // 64th header closes a window
    localparam logic [4:0] INV_LAST  = 5'd15;   // 16th invalid header drops lock
    localparam logic [4:0] BER_LIMIT = 5'd16;

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_SLIP     = 2'd1,
        ST_LOCKED   = 2'd2
    } state_t;

    state_t              state_q,      state_d;
    logic [6:0]          sh_cnt_q,     sh_cnt_d;
    logic [4:0]          sh_inv_cnt_q, sh_inv_cnt_d;
    logic [SLIP_W-1:0]   slip_cnt_q,   slip_cnt_d;
    logic                bitslip_q,    bitslip_d;
    logic                lock_q,       lock_d;
    logic [TIMER_W-1:0]  timer_q,      timer_d;
    logic [4:0]          ber_cnt_q,    ber_cnt_d;
    logic                high_ber_q,   high_ber_d;
    logic                status_q,     status_d;
    logic [15:0]         bad_cnt_q,    bad_cnt_d;

    logic                w_hdr_bad;
    logic                w_bad_evt;
    logic [4:0]          w_ber_next;

    // A sync header is invalid when both bits are equal (00 or 11)
    assign w_hdr_bad = ~^serdes_rx_hdr;
    assign w_bad_evt = serdes_rx_hdr_valid & w_hdr_bad;

    // Lock acquisition / loss state machine
    always_comb begin
        state_d      = state_q;
        sh_cnt_d     = sh_cnt_q;
        sh_inv_cnt_d = sh_inv_cnt_q;
        slip_cnt_d   = slip_cnt_q;
        bitslip_d    = 1'b0;
        lock_d       = lock_q;

        case (state_q)
            ST_UNLOCKED: begin
                lock_d = 1'b0;
                if (serdes_rx_hdr_valid) begin
                    if (w_hdr_bad) begin
                        bitslip_d  = 1'b1;
                        sh_cnt_d   = 7'd0;
                        slip_cnt_d = '0;
                        state_d    = ST_SLIP;
                    end else if (sh_cnt_q == SH_LAST) begin
                        lock_d       = 1'b1;
                        sh_cnt_d     = 7'd0;
                        sh_inv_cnt_d = 5'd0;
                        state_d      = ST_LOCKED;
                    end else begin
                        sh_cnt_d = sh_cnt_q + 7'd1;
                    end
                end
            end

            ST_SLIP: begin
                // Headers are meaningless while the SERDES realigns; wait in clk cycles
                lock_d       = 1'b0;
                sh_cnt_d     = 7'd0;
                sh_inv_cnt_d = 5'd0;
                if (slip_cnt_q == SLIP_LAST) begin
                    slip_cnt_d = '0;
                    state_d    = ST_UNLOCKED;
                end else begin
                    slip_cnt_d = slip_cnt_q + 1'b1;
                end
            end

            ST_LOCKED: begin
                lock_d = 1'b1;
                if (serdes_rx_hdr_valid) begin
                    // Loss of lock is checked first so it wins over the window end
                    if (w_hdr_bad && (sh_inv_cnt_q == INV_LAST)) begin
                        lock_d       = 1'b0;
                        bitslip_d    = 1'b1;
                        sh_cnt_d     = 7'd0;
                        sh_inv_cnt_d = 5'd0;
                        slip_cnt_d   = '0;
                        state_d      = ST_SLIP;
                    end else if (sh_cnt_q == SH_LAST) begin
                        sh_cnt_d     = 7'd0;
                        sh_inv_cnt_d = 5'd0;
                    end else begin
                        sh_cnt_d = sh_cnt_q + 7'd1;
                        if (w_hdr_bad) begin
                            sh_inv_cnt_d = sh_inv_cnt_q + 5'd1;
                        end
                    end
                end
            end

            default: begin
                lock_d       = 1'b0;
                sh_cnt_d     = 7'd0;
                sh_inv_cnt_d = 5'd0;
                slip_cnt_d   = '0;
                state_d      = ST_UNLOCKED;
            end
        endcase
    end

    // BER monitor: error count per 125 us window, only while lock is held
    always_comb begin
        timer_d    = timer_q;
        ber_cnt_d  = ber_cnt_q;
        high_ber_d = high_ber_q;
        w_ber_next = ber_cnt_q;

        if (!(lock_q && lock_d)) begin
            timer_d    = '0;
            ber_cnt_d  = 5'd0;
            high_ber_d = 1'b0;
        end else begin
            if (w_bad_evt && (ber_cnt_q != BER_LIMIT)) begin
                w_ber_next = ber_cnt_q + 5'd1;
            end
            if (w_ber_next == BER_LIMIT) begin
                high_ber_d = 1'b1;
            end
            if (timer_q == TIMER_LAST) begin
                // Window end: clear only if this window stayed below the limit
                timer_d   = '0;
                ber_cnt_d = 5'd0;
                if (w_ber_next != BER_LIMIT) begin
                    high_ber_d = 1'b0;
                end
            end else begin
                timer_d   = timer_q + 1'b1;
                ber_cnt_d = w_ber_next;
            end
        end
    end

    // Saturating invalid-header counter, cleared only by reset
    always_comb begin
        bad_cnt_d = bad_cnt_q;
        if ((state_q == ST_LOCKED) && w_bad_evt && (bad_cnt_q != 16'hFFFF)) begin
            bad_cnt_d = bad_cnt_q + 16'd1;
        end
    end

    // Registered status so it is aligned with lock and high-BER outputs
    always_comb begin
        status_d = lock_d & ~high_ber_d;
    end

    // State and counter registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_UNLOCKED;
            sh_cnt_q     <= 7'd0;
            sh_inv_cnt_q <= 5'd0;
            slip_cnt_q   <= '0;
            bitslip_q    <= 1'b0;
            lock_q       <= 1'b0;
            timer_q      <= '0;
            ber_cnt_q    <= 5'd0;
            high_ber_q   <= 1'b0;
            status_q     <= 1'b0;
            bad_cnt_q    <= 16'd0;
        end else begin
            state_q      <= state_d;
            sh_cnt_q     <= sh_cnt_d;
            sh_inv_cnt_q <= sh_inv_cnt_d;
            slip_cnt_q   <= slip_cnt_d;
            bitslip_q    <= bitslip_d;
            lock_q       <= lock_d;
            timer_q      <= timer_d;
            ber_cnt_q    <= ber_cnt_d;
            high_ber_q   <= high_ber_d;
            status_q     <= status_d;
            bad_cnt_q    <= bad_cnt_d;
        end
    end

    assign serdes_rx_bitslip = bitslip_q;
    assign rx_block_lock     = lock_q;
    assign rx_high_ber       = high_ber_q;
    assign rx_status         = status_q;
    assign rx_bad_hdr_cnt    = bad_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_taxi_eth_phy_10g_rx_frame_sync.sv
`default_nettype none
// ============================================================================
// Module      : tb_taxi_eth_phy_10g_rx_frame_sync
// Description : Directed self-checking bench for the 10G RX frame sync.
//               Expected outputs are queued before each step and compared
//               after the clock edge that samples the stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_taxi_eth_phy_10g_rx_frame_sync;

    localparam int BITSLIP_WAIT = 8;
    localparam int COUNT_125US  = 100;

    localparam logic [1:0] HDR_OK  = 2'b01;
    localparam logic [1:0] HDR_BAD = 2'b11;
    localparam logic [1:0] HDR_ZZ  = 2'b00;

    localparam int SEL_LOCK  = 0;
    localparam int SEL_HBER  = 1;
    localparam int SEL_STAT  = 2;
    localparam int SEL_SLIP  = 3;
    localparam int SEL_BAD   = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  serdes_rx_hdr;
    logic        serdes_rx_hdr_valid;
    logic        serdes_rx_bitslip;
    logic        rx_block_lock;
    logic        rx_high_ber;
    logic        rx_status;
    logic [15:0] rx_bad_hdr_cnt;

    typedef struct {
        string       tag;
        int          sel;
        logic [15:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    taxi_eth_phy_10g_rx_frame_sync #(
        .HDR_W        (2),
        .BITSLIP_WAIT (BITSLIP_WAIT),
        .COUNT_125US  (COUNT_125US)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .serdes_rx_hdr       (serdes_rx_hdr),
        .serdes_rx_hdr_valid (serdes_rx_hdr_valid),
        .serdes_rx_bitslip   (serdes_rx_bitslip),
        .rx_block_lock       (rx_block_lock),
        .rx_high_ber         (rx_high_ber),
        .rx_status           (rx_status),
        .rx_bad_hdr_cnt      (rx_bad_hdr_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] get_obs(input int sel);
        case (sel)
            SEL_LOCK: return {15'd0, rx_block_lock};
            SEL_HBER: return {15'd0, rx_high_ber};
            SEL_STAT: return {15'd0, rx_status};
            SEL_SLIP: return {15'd0, serdes_rx_bitslip};
            default:  return rx_bad_hdr_cnt;
        endcase
    endfunction

    task automatic expect_val(input string tag, input int sel, input logic [15:0] v);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = v;
        sb.push_back(e);
    endtask

    // Queue a full set of output expectations; status follows from lock and BER
    task automatic exp_outs(input string tag, input logic lock, input logic hber,
                            input logic slip, input logic [15:0] bad);
        expect_val({tag, "_lock"}, SEL_LOCK, {15'd0, lock});
        expect_val({tag, "_hber"}, SEL_HBER, {15'd0, hber});
        expect_val({tag, "_stat"}, SEL_STAT, {15'd0, lock & ~hber});
        expect_val({tag, "_slip"}, SEL_SLIP, {15'd0, slip});
        expect_val({tag, "_bad"},  SEL_BAD,  bad);
    endtask

    task automatic check_sb();
        exp_t        e;
        logic [15:0] obs;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = get_obs(e.sel);
            n_assert++;
            assert (obs === e.val) else begin
                n_fail++;
                $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
            end
        end
    endtask

    // Drive one header, let the DUT sample it, then compare queued expectations
    task automatic step(input logic [1:0] h, input logic v);
        serdes_rx_hdr       = h;
        serdes_rx_hdr_valid = v;
        @(posedge clk);
        #1;
        check_sb();
    endtask

    task automatic run(input logic [1:0] h, input logic v, input int n);
        for (int i = 0; i < n; i++) begin
            step(h, v);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst                 = 1'b1;
        serdes_rx_hdr       = HDR_ZZ;
        serdes_rx_hdr_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        exp_outs("reset", 1'b0, 1'b0, 1'b0, 16'd0);
        check_sb();
        rst = 1'b0;

        // Lock after exactly 64 consecutive valid headers
        run(HDR_OK, 1'b1, 62);
        exp_outs("t1_63", 1'b0, 1'b0, 1'b0, 16'd0);
        step(HDR_OK, 1'b1);
        exp_outs("t1_64", 1'b1, 1'b0, 1'b0, 16'd0);
        step(HDR_OK, 1'b1);

        // Unlocked: invalid header slips, then headers ignored for 8 cycles
        do_reset();
        run(HDR_OK, 1'b1, 10);
        exp_outs("t2_slip", 1'b0, 1'b0, 1'b1, 16'd0);
        step(HDR_BAD, 1'b1);
        for (int i = 0; i < BITSLIP_WAIT; i++) begin
            expect_val("t2_wait", SEL_SLIP, 16'd0);
            step(HDR_ZZ, 1'b1);
        end
        expect_val("t2_slip_again", SEL_SLIP, 16'd1);
        step(HDR_BAD, 1'b1);
        for (int i = 0; i < BITSLIP_WAIT; i++) begin
            expect_val("t2_wait_ok", SEL_SLIP, 16'd0);
            step(HDR_OK, 1'b1);
        end
        run(HDR_OK, 1'b1, 62);
        exp_outs("t2_63", 1'b0, 1'b0, 1'b0, 16'd0);
        step(HDR_OK, 1'b1);
        exp_outs("t2_lock", 1'b1, 1'b0, 1'b0, 16'd0);
        step(HDR_OK, 1'b1);

        // Locked: 15 invalid in a 64-header window keeps lock
        run(HDR_BAD, 1'b1, 15);
        run(HDR_OK, 1'b1, 48);
        exp_outs("t3_w1", 1'b1, 1'b0, 1'b0, 16'd15);
        step(HDR_OK, 1'b1);
        // Same BER window already holds 15 errors, so the next one trips high BER
        exp_outs("t3_ber", 1'b1, 1'b1, 1'b0, 16'd16);
        step(HDR_BAD, 1'b1);
        run(HDR_BAD, 1'b1, 14);
        expect_val("t3_loss_lock", SEL_LOCK, 16'd0);
        expect_val("t3_loss_slip", SEL_SLIP, 16'd1);
        expect_val("t3_loss_stat", SEL_STAT, 16'd0);
        expect_val("t3_loss_bad",  SEL_BAD,  16'd31);
        step(HDR_BAD, 1'b1);
        expect_val("t3_pulse_end", SEL_SLIP, 16'd0);
        step(HDR_OK, 1'b1);
        run(HDR_OK, 1'b1, BITSLIP_WAIT - 1);
        run(HDR_OK, 1'b1, 62);
        exp_outs("t3_pre_relock", 1'b0, 1'b0, 1'b0, 16'd31);
        step(HDR_OK, 1'b1);
        exp_outs("t3_relock", 1'b1, 1'b0, 1'b0, 16'd31);
        step(HDR_OK, 1'b1);

        // 16 errors spread over four 100-cycle BER windows: no high BER
        for (int w = 0; w < 4; w++) begin
            run(HDR_BAD, 1'b1, 4);
            run(HDR_OK, 1'b1, 95);
            exp_outs("t4_win", 1'b1, 1'b0, 1'b0, 16'(31 + 4 * (w + 1)));
            step(HDR_OK, 1'b1);
        end

        // 16 errors inside one BER window, split across two sync-header windows
        run(HDR_BAD, 1'b1, 8);
        run(HDR_OK, 1'b1, 40);
        run(HDR_BAD, 1'b1, 6);
        expect_val("t4_15", SEL_HBER, 16'd0);
        step(HDR_BAD, 1'b1);
        exp_outs("t4_16", 1'b1, 1'b1, 1'b0, 16'd63);
        step(HDR_BAD, 1'b1);
        run(HDR_OK, 1'b1, 43);
        exp_outs("t4_hold", 1'b1, 1'b1, 1'b0, 16'd63);
        step(HDR_OK, 1'b1);
        run(HDR_OK, 1'b1, 98);
        expect_val("t4_pre_clear", SEL_HBER, 16'd1);
        step(HDR_OK, 1'b1);
        exp_outs("t4_clear", 1'b1, 1'b0, 1'b0, 16'd63);
        step(HDR_OK, 1'b1);

        // Qualifier toggling: invalid headers on stall cycles must be ignored
        for (int i = 0; i < 63; i++) begin
            step(HDR_OK, 1'b1);
            step(HDR_BAD, 1'b0);
        end
        step(HDR_OK, 1'b1);
        exp_outs("t5_toggle", 1'b1, 1'b0, 1'b0, 16'd63);
        step(HDR_BAD, 1'b0);

        // 16th error lands on the BER timer wrap edge
        run(HDR_OK, 1'b1, 32);
        run(HDR_BAD, 1'b1, 8);
        run(HDR_OK, 1'b1, 24);
        run(HDR_BAD, 1'b1, 6);
        expect_val("t5_pre_wrap", SEL_HBER, 16'd0);
        step(HDR_BAD, 1'b1);
        exp_outs("t5_wrap", 1'b1, 1'b1, 1'b0, 16'd79);
        step(HDR_BAD, 1'b1);

        // Asynchronous reset between clock edges while locked with high BER
        #2;
        rst = 1'b1;
        #1;
        exp_outs("t6_async", 1'b0, 1'b0, 1'b0, 16'd0);
        check_sb();
        @(posedge clk);
        #1;
        rst = 1'b0;
        run(HDR_OK, 1'b1, 62);
        exp_outs("t6_63", 1'b0, 1'b0, 1'b0, 16'd0);
        step(HDR_OK, 1'b1);
        exp_outs("t6_relock", 1'b1, 1'b0, 1'b0, 16'd0);
        step(HDR_OK, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
